// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard beside ID: stalls a consumer until every
// in-flight producer it reads can be forwarded, and counts stall cycles.
module hazard_scoreboard #(
    parameter int unsigned REG_COUNT = 32,
    parameter int unsigned REG_W     = 5,
    parameter int unsigned ALU_LAT   = 0,
    parameter int unsigned LOAD_LAT  = 1,
    parameter int unsigned CNT_W     = 3,
    parameter int unsigned STAT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [REG_W-1:0]     issue_src1,
    input  logic [REG_W-1:0]     issue_src2,
    input  logic                 issue_use_src2,
    input  logic [REG_W-1:0]     issue_dst,
    input  logic                 issue_wb_en,
    input  logic                 issue_is_load,
    input  logic                 flush,
    output logic                 stall,
    output logic [REG_COUNT-1:0] pending_mask,
    output logic [STAT_W-1:0]    stall_cycles,
    input  logic                 stat_clr
);

    localparam int unsigned IdxSpan = 2 ** REG_W;
    localparam logic [CNT_W-1:0] AluLat  = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] LoadLat = CNT_W'(LOAD_LAT);

    logic [CNT_W-1:0]   cnt_q [REG_COUNT];
    logic [CNT_W-1:0]   cnt_d [REG_COUNT];
    logic [IdxSpan-1:0] busy;
    logic               src1_busy;
    logic               src2_busy;
    logic               accept;
    logic [STAT_W-1:0]  stall_cycles_q;
    logic [STAT_W-1:0]  stall_cycles_d;

    always_comb begin
        for (int unsigned r = 0; r < REG_COUNT; r++) begin
            pending_mask[r] = (cnt_q[r] != '0);
        end
    end

    // Pad to the full index space so out-of-range sources read as idle.
    always_comb begin
        busy                  = '0;
        busy[REG_COUNT-1:0]   = pending_mask;
        busy[0]               = 1'b0;
    end

    assign src1_busy = busy[issue_src1];
    assign src2_busy = busy[issue_src2];
    assign stall     = issue_valid & ~flush & (src1_busy | (issue_use_src2 & src2_busy));
    assign accept    = issue_valid & ~flush & ~stall;

    // A fresh issue overrides the running countdown (youngest writer wins).
    always_comb begin
        for (int unsigned r = 0; r < REG_COUNT; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r == 0) begin
                cnt_d[r] = '0;
            end else if (accept && issue_wb_en && (issue_dst == REG_W'(r))) begin
                cnt_d[r] = issue_is_load ? LoadLat : AluLat;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stat_clr) begin
            stall_cycles_d = '0;
        end else if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < REG_COUNT; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cycles_q <= '0;
        end else begin
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: default-latency instance driven from a vector table, plus a
// LOAD_LAT=3 instance exercised by hand-written multi-cycle sequences.
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_src1;
    logic [4:0]  issue_src2;
    logic        issue_use_src2;
    logic [4:0]  issue_dst;
    logic        issue_wb_en;
    logic        issue_is_load;
    logic        flush;
    logic        stat_clr;

    logic        a_stall;
    logic [31:0] a_mask;
    logic [15:0] a_cyc;
    logic        b_stall;
    logic [31:0] b_mask;
    logic [15:0] b_cyc;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_scoreboard u_dut_a (
        .clk            (clk),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_src1     (issue_src1),
        .issue_src2     (issue_src2),
        .issue_use_src2 (issue_use_src2),
        .issue_dst      (issue_dst),
        .issue_wb_en    (issue_wb_en),
        .issue_is_load  (issue_is_load),
        .flush          (flush),
        .stall          (a_stall),
        .pending_mask   (a_mask),
        .stall_cycles   (a_cyc),
        .stat_clr       (stat_clr)
    );

    hazard_scoreboard #(
        .LOAD_LAT (3)
    ) u_dut_b (
        .clk            (clk),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_src1     (issue_src1),
        .issue_src2     (issue_src2),
        .issue_use_src2 (issue_use_src2),
        .issue_dst      (issue_dst),
        .issue_wb_en    (issue_wb_en),
        .issue_is_load  (issue_is_load),
        .flush          (flush),
        .stall          (b_stall),
        .pending_mask   (b_mask),
        .stall_cycles   (b_cyc),
        .stat_clr       (stat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic        use2;
        logic [4:0]  dst;
        logic        wb;
        logic        load;
        logic        fl;
        logic        clr;
        logic        exp_stall;
        logic [31:0] exp_mask;
        logic [15:0] exp_cyc;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic u2, input logic [4:0] d, input logic wb,
                         input logic ld, input logic fl, input logic clr);
        issue_valid    = v;
        issue_src1     = s1;
        issue_src2     = s2;
        issue_use_src2 = u2;
        issue_dst      = d;
        issue_wb_en    = wb;
        issue_is_load  = ld;
        flush          = fl;
        stat_clr       = clr;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Inputs change and outputs are sampled 2-4 time units after a rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // valid src1 src2 use2 dst wb load flush clr | stall mask cyc
        tbl[0]  = '{1, 1,  0, 0, 4,  1, 1, 0, 0, 0, 32'h0,   0};  // LW r4
        tbl[1]  = '{1, 4,  0, 0, 5,  1, 0, 0, 0, 1, 32'h10,  0};  // load-use stall
        tbl[2]  = '{1, 4,  0, 0, 5,  1, 0, 0, 0, 0, 32'h0,   1};  // accepted
        tbl[3]  = '{1, 1,  0, 0, 6,  1, 0, 0, 0, 0, 32'h0,   1};  // ADD r6
        tbl[4]  = '{1, 6,  6, 1, 7,  1, 0, 0, 0, 0, 32'h0,   1};  // SUB r6,r6
        tbl[5]  = '{1, 2,  0, 0, 0,  1, 1, 0, 0, 0, 32'h0,   1};  // LW r0
        tbl[6]  = '{1, 0,  0, 1, 8,  1, 0, 0, 0, 0, 32'h0,   1};  // reads r0
        tbl[7]  = '{1, 1,  0, 0, 7,  1, 1, 0, 0, 0, 32'h0,   1};  // LW r7
        tbl[8]  = '{1, 7,  0, 0, 9,  1, 1, 1, 0, 0, 32'h80,  1};  // flushed consumer
        tbl[9]  = '{0, 9,  9, 1, 0,  0, 0, 0, 0, 0, 32'h0,   1};  // r9 never set
        tbl[10] = '{1, 1,  0, 0, 7,  1, 1, 0, 0, 0, 32'h0,   1};  // LW r7
        tbl[11] = '{1, 1,  7, 0, 8,  1, 0, 0, 0, 0, 32'h80,  1};  // ADDI, src2 unused
        tbl[12] = '{0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 32'h0,   1};
        tbl[13] = '{1, 1,  0, 0, 3,  1, 1, 0, 0, 0, 32'h0,   1};  // LW r3
        tbl[14] = '{1, 3,  0, 0, 3,  1, 0, 0, 0, 1, 32'h8,   1};  // r3=r3+1 stalls
        tbl[15] = '{1, 3,  0, 0, 3,  1, 0, 0, 0, 0, 32'h0,   2};
        tbl[16] = '{0, 0,  0, 0, 0,  0, 0, 0, 1, 0, 32'h0,   2};  // stat_clr
        tbl[17] = '{0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 32'h0,   0};
        tbl[18] = '{1, 1,  0, 0, 10, 1, 1, 0, 0, 0, 32'h0,   0};  // LW r10
        tbl[19] = '{1, 10, 0, 0, 11, 1, 0, 0, 1, 1, 32'h400, 0};  // clr beats incr
        tbl[20] = '{1, 10, 0, 0, 11, 1, 0, 0, 0, 0, 32'h0,   0};

        // Reset held with a would-be consumer present.
        reset = 1'b0;
        drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        check("rst_a_stall", a_stall, 0);
        check("rst_a_mask", a_mask, 0);
        check("rst_a_cyc", a_cyc, 0);
        check("rst_b_stall", b_stall, 0);
        step();
        step();
        reset = 1'b1;
        step();
        check("rel_a_stall", a_stall, 0);
        check("rel_a_mask", a_mask, 0);
        check("rel_a_cyc", a_cyc, 0);

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].valid, tbl[i].src1, tbl[i].src2, tbl[i].use2, tbl[i].dst,
                  tbl[i].wb, tbl[i].load, tbl[i].fl, tbl[i].clr);
            #1;
            check($sformatf("v%0d_stall", i), a_stall, tbl[i].exp_stall);
            check($sformatf("v%0d_mask", i), a_mask, tbl[i].exp_mask);
            check($sformatf("v%0d_cyc", i), a_cyc, tbl[i].exp_cyc);
            step();
        end

        // LOAD_LAT=3 load-use: three stall cycles.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        step();
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check("b_lw9_stall", b_stall, 0);
        step();
        drive(1'b1, 5'd9, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("b_use9_stall%0d", k), b_stall, (k < 3) ? 1 : 0);
            check($sformatf("b_use9_pend%0d", k), b_mask[9], (k < 3) ? 1 : 0);
            step();
        end
        idle();
        #1;
        check("b_use9_mask", b_mask, 0);
        check("b_use9_cyc", b_cyc, 3);
        step();

        // WAW: ALU write to r2 one cycle behind a load to r2.
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        step();
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("b_waw_mask0", b_mask, 32'h4);
        check("b_waw_stall", b_stall, 0);
        step();
        idle();
        #1;
        check("b_waw_mask1", b_mask, 0);
        step();

        // Asynchronous reset while cnt[2]=2.
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        step();
        idle();
        step();
        drive(1'b1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("b_pre_rst_mask", b_mask, 32'h4);
        check("b_pre_rst_stall", b_stall, 1);
        reset = 1'b0;
        #1;
        check("b_mid_rst_mask", b_mask, 0);
        check("b_mid_rst_stall", b_stall, 0);
        check("b_mid_rst_cyc", b_cyc, 0);
        reset = 1'b1;
        step();
        #1;
        check("b_post_rst_mask", b_mask, 0);
        check("b_post_rst_stall", b_stall, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed load-use hazard detector in the 5-stage pipeline.
- Tracks, per architectural register, how many cycles remain until an in-flight result can be forwarded.
- Sits beside the ID stage. Its `stall` output drives the same freeze path as the current hazard_detected, for IF/ID hold and an ID/EXE bubble.
- Supports configurable ALU and load latencies, a flush-squash, a pending-register bitmap and a saturating stall-cycle counter.

Parameters:
- REG_COUNT, 32: number of architectural registers. Register 0 is hardwired zero and never tracked.
- REG_W, 5: register index width; must satisfy 2^REG_W >= REG_COUNT.
- ALU_LAT, 0: stall cycles a consumer needs behind an ALU producer. 0 means fully forwarded.
- LOAD_LAT, 1: stall cycles a consumer needs behind a load producer.
- CNT_W, 3: per-register countdown width; ALU_LAT and LOAD_LAT must be <= 2^CNT_W-1.
- STAT_W, 16: stall statistic counter width.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- issue_valid, input, 1: ID holds a real instruction this cycle.
- issue_src1, input, REG_W: first source register.
- issue_src2, input, REG_W: second source register.
- issue_use_src2, input, 1: src2 is read (register-form ALU, ST, BNE); 0 for immediate forms.
- issue_dst, input, REG_W: destination register.
- issue_wb_en, input, 1: instruction writes issue_dst.
- issue_is_load, input, 1: instruction is a load (selects LOAD_LAT).
- flush, input, 1: squash the ID instruction this cycle (branch taken).
- stall, output, 1: hold IF/ID and inject a bubble into ID/EXE.
- pending_mask, output, REG_COUNT: bit r = cnt[r] != 0.
- stall_cycles, output, STAT_W: count of cycles with stall=1, saturating.
- stat_clr, input, 1: synchronous clear of stall_cycles.

Behaviour:
- State: cnt[1..REG_COUNT-1], each CNT_W bits; cnt[0] is constant 0.
- Reset (reset=0, asynchronous): all cnt=0 and stall_cycles=0. Hence pending_mask=0 and stall=0.
- Reset mid-operation discards all tracking immediately. No stale stall may appear after reset releases.
- stall is combinational, zero latency:
  - stall = issue_valid & !flush & (cnt[src1]!=0 | (issue_use_src2 & cnt[src2]!=0)).
  - Source index 0 never causes a stall.
- accept = issue_valid & !flush & !stall.
- Per-cycle update, every register r >= 1:
  - If accept & issue_wb_en & issue_dst==r & issue_dst!=0: cnt[r] <= (issue_is_load ? LOAD_LAT : ALU_LAT).
  - Else if cnt[r]!=0: cnt[r] <= cnt[r]-1.
  - Else cnt[r] holds.
- Simultaneous decrement and new issue to the same register: the new issue value wins, giving WAW-youngest semantics.
- A producer may read its own dst as a source (e.g. r3=r3+1). The stall check uses the pre-update cnt; the update then applies.
- Latency 0 producers never set a pending bit.
- Out-of-range indices (>= REG_COUNT) are treated as never pending.
- Stalled or flushed instructions do not modify cnt; decrements of other registers continue.
- flush overrides stall, so a squashed instruction never holds the pipe.
- stall_cycles: increments by 1 each cycle stall=1, saturating at 2^STAT_W-1.
  - stat_clr=1 sets it to 0 and takes priority over the increment.
- pending_mask is combinational from cnt, i.e. registered-state derived.
- Equivalence requirement: with ALU_LAT=0 and LOAD_LAT=1, stall must match the existing load-use detection cycle-for-cycle.

Test Plan:
- Reset: hold reset=0 with issue_valid=1, src1=5 -> stall=0, pending_mask=0, stall_cycles=0. Release; no change.
- Load-use: cycle0 LW r4 (dst=4, is_load=1, accepted); cycle1 ADD src1=4 -> stall=1 for exactly 1 cycle, accepted in cycle2, stall_cycles=1.
- ALU back-to-back: ADD r6 then SUB src1=6, src2=6, use_src2=1 -> stall=0, pending_mask[6]=0 throughout.
- Parametrised latency: LOAD_LAT=3; LW r9 then consumer of r9 -> stall held 3 cycles. pending_mask[9] high 3 cycles then low.
- Immediate/zero/flush:
  - LW r0, then consumer src1=0 -> no stall.
  - LW r7, then ADDI with src2=7 and use_src2=0 -> no stall.
  - Consumer of r7 with flush=1 -> stall=0 and cnt unchanged.
- WAW and reset mid-op:
  - LOAD_LAT=3: LW r2, then after 1 cycle ALU r2 (ALU_LAT=0) -> pending_mask[2] clears next cycle.
  - Separately, assert reset while cnt[2]=2 -> pending_mask=0 immediately.
